// File: rtl/snake_body_queue.sv
// Snake body held as a circular coordinate queue: steps the head per game tick,
// grows, wraps or dies at the walls, and scans the body for self-collision.
module snake_body_queue #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int COORD_W  = 6,
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 7,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 20,
  parameter int INIT_Y   = 15,
  parameter int WRAP     = 0
) (
  input  logic               clk_25M,
  input  logic               rst,
  input  logic               step,
  input  logic [1:0]         dir,
  input  logic               grow,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [COORD_W-1:0] tail_x,
  output logic [COORD_W-1:0] tail_y,
  output logic [COORD_W-1:0] vac_x,
  output logic [COORD_W-1:0] vac_y,
  output logic               vac_valid,
  output logic [LEN_W-1:0]   length,
  output logic               full,
  output logic               busy,
  output logic               done,
  output logic               dead
);
  // state | meaning
  // INIT  | writing the initial body, one segment per cycle, tail first
  // IDLE  | waiting for a game tick
  // MOVE  | push new head, pop tail unless growing
  // SCAN  | compare new head against body, tail up to head
  // DEAD  | game over, outputs frozen until rst
  localparam int PTR_W = $clog2(MAX_LEN);
  localparam int CW1   = COORD_W + 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_MOVE, S_SCAN, S_DEAD} state_t;

  state_t             state_q, state_d;
  logic [1:0]         heading_q, heading_d;
  logic               grow_q, grow_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, scan_ptr_q, scan_ptr_d;
  logic [LEN_W-1:0]   len_q, len_d, scan_cnt_q, scan_cnt_d;
  logic [COORD_W-1:0] vac_x_q, vac_x_d, vac_y_q, vac_y_d;
  logic               vac_valid_q, vac_valid_d, done_q, done_d;

  logic [COORD_W-1:0] qx_q [MAX_LEN];
  logic [COORD_W-1:0] qy_q [MAX_LEN];

  logic               wr_en;
  logic [COORD_W-1:0] wr_x, wr_y;
  logic [PTR_W-1:0]   head_ptr;
  logic [CW1-1:0]     nx_raw, ny_raw, nx, ny;
  logic               oob, reverse;

  assign head_ptr  = wr_ptr_q - PTR_W'(1);
  assign head_x    = qx_q[head_ptr];
  assign head_y    = qy_q[head_ptr];
  assign tail_x    = qx_q[rd_ptr_q];
  assign tail_y    = qy_q[rd_ptr_q];
  assign vac_x     = vac_x_q;
  assign vac_y     = vac_y_q;
  assign vac_valid = vac_valid_q;
  assign length    = len_q;
  assign full      = (len_q == LEN_W'(MAX_LEN));
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign dead      = (state_q == S_DEAD);
  assign reverse   = (dir[1] == heading_q[1]) && (dir[0] != heading_q[0]);

  // Extra top bit lets -1 show up as an out-of-range value rather than aliasing.
  always_comb begin
    nx_raw = {1'b0, head_x};
    ny_raw = {1'b0, head_y};
    case (heading_q)
      2'd0:    ny_raw = {1'b0, head_y} - CW1'(1);
      2'd1:    ny_raw = {1'b0, head_y} + CW1'(1);
      2'd2:    nx_raw = {1'b0, head_x} - CW1'(1);
      default: nx_raw = {1'b0, head_x} + CW1'(1);
    endcase
    oob = (nx_raw >= CW1'(GRID_W)) || (ny_raw >= CW1'(GRID_H));
    nx  = nx_raw;
    ny  = ny_raw;
    if (WRAP != 0) begin
      if (nx_raw == {CW1{1'b1}})          nx = CW1'(GRID_W - 1);
      else if (nx_raw == CW1'(GRID_W))    nx = '0;
      if (ny_raw == {CW1{1'b1}})          ny = CW1'(GRID_H - 1);
      else if (ny_raw == CW1'(GRID_H))    ny = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    heading_d   = heading_q;
    grow_d      = grow_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    scan_ptr_d  = scan_ptr_q;
    len_d       = len_q;
    scan_cnt_d  = scan_cnt_q;
    vac_x_d     = vac_x_q;
    vac_y_d     = vac_y_q;
    vac_valid_d = 1'b0;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    wr_x        = '0;
    wr_y        = '0;
    case (state_q)
      S_INIT: begin
        wr_en    = 1'b1;
        wr_x     = COORD_W'(INIT_X - INIT_LEN + 1) + COORD_W'(len_q);
        wr_y     = COORD_W'(INIT_Y);
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        len_d    = len_q + LEN_W'(1);
        if (len_q == LEN_W'(INIT_LEN - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (step) begin
          grow_d = grow;
          if (!reverse || len_q == LEN_W'(1)) heading_d = dir;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (oob && WRAP == 0) begin
          state_d = S_DEAD;
        end else begin
          wr_en    = 1'b1;
          wr_x     = nx[COORD_W-1:0];
          wr_y     = ny[COORD_W-1:0];
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (grow_q && !full) begin
            len_d      = len_q + LEN_W'(1);
            scan_cnt_d = len_q;
          end else begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            vac_x_d     = tail_x;
            vac_y_d     = tail_y;
            vac_valid_d = 1'b1;
            scan_cnt_d  = len_q - LEN_W'(1);
          end
          scan_ptr_d = rd_ptr_d;
          if (scan_cnt_d == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (qx_q[scan_ptr_q] == head_x && qy_q[scan_ptr_q] == head_y) begin
          state_d = S_DEAD;
        end else if (scan_cnt_q == LEN_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          scan_ptr_d = scan_ptr_q + PTR_W'(1);
          scan_cnt_d = scan_cnt_q - LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25M) begin
    if (rst) begin
      state_q     <= S_INIT;
      heading_q   <= 2'd3;
      grow_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      scan_ptr_q  <= '0;
      len_q       <= '0;
      scan_cnt_q  <= '0;
      vac_x_q     <= '0;
      vac_y_q     <= '0;
      vac_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      heading_q   <= heading_d;
      grow_q      <= grow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      scan_ptr_q  <= scan_ptr_d;
      len_q       <= len_d;
      scan_cnt_q  <= scan_cnt_d;
      vac_x_q     <= vac_x_d;
      vac_y_q     <= vac_y_d;
      vac_valid_q <= vac_valid_d;
      done_q      <= done_d;
      if (wr_en) begin
        qx_q[wr_ptr_q] <= wr_x;
        qy_q[wr_ptr_q] <= wr_y;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_queue.sv
// Directed bench for snake_body_queue: a wall-death instance and a wrap instance
// share clock and stimulus.
module tb_snake_body_queue;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic [1:0] dir = 2'd3;
  logic       grow = 1'b0;

  logic [5:0] h0x, h0y, t0x, t0y, v0x, v0y, h1x, h1y, t1x, t1y, v1x, v1y;
  logic [6:0] len0, len1;
  logic       vv0, full0, busy0, done0, dead0;
  logic       vv1, full1, busy1, done1, dead1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snake_body_queue #(.WRAP(0)) u_dut (
    .clk_25M(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
    .head_x(h0x), .head_y(h0y), .tail_x(t0x), .tail_y(t0y),
    .vac_x(v0x), .vac_y(v0y), .vac_valid(vv0), .length(len0),
    .full(full0), .busy(busy0), .done(done0), .dead(dead0));

  snake_body_queue #(.WRAP(1)) u_wrap (
    .clk_25M(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
    .head_x(h1x), .head_y(h1y), .tail_x(t1x), .tail_y(t1y),
    .vac_x(v1x), .vac_y(v1y), .vac_valid(vv1), .length(len1),
    .full(full1), .busy(busy1), .done(done1), .dead(dead1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    int n;
    rst = 1'b1; step = 1'b0; grow = 1'b0;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (busy0) begin
      fails++;
      $display("FAIL reset_timeout busy=%0d want 0", busy0);
    end
  endtask

  // Issues one tick and waits until both instances are idle or dead.
  task automatic step_wait(input logic [1:0] d, input logic g, output int cyc,
                           output bit sd0, output bit sv0, output bit sd1);
    int n;
    bit fin;
    dir = d; grow = g; step = 1'b1;
    tick();
    step = 1'b0;
    n = 1;
    sd0 = done0; sv0 = vv0; sd1 = done1;
    fin = (!busy0 || dead0) && (!busy1 || dead1);
    while (!fin && n < 300) begin
      tick();
      n++;
      sd0 |= done0; sv0 |= vv0; sd1 |= done1;
      fin = (!busy0 || dead0) && (!busy1 || dead1);
    end
    tests++;
    if (!fin) begin
      fails++;
      $display("FAIL step_timeout cycles=%0d want <300", n);
    end
    cyc = n;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy0, dead0, done0, vv0, len0} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
      fails++;
      $display("FAIL reset_flags busy=%0d dead=%0d done=%0d vv=%0d len=%0d want 1 0 0 0 0",
               busy0, dead0, done0, vv0, len0);
    end
    tests++;
    if ({v0x, v0y} !== 12'd0) begin
      fails++;
      $display("FAIL reset_vac got (%0d,%0d) want (0,0)", v0x, v0y);
    end
    n = 0;
    while (busy0 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL init_cycles got %0d want 3", n);
    end
    tests++;
    if ({h0x, h0y, t0x, t0y} !== {6'd20, 6'd15, 6'd18, 6'd15}) begin
      fails++;
      $display("FAIL init_pos head (%0d,%0d) tail (%0d,%0d) want (20,15) (18,15)",
               h0x, h0y, t0x, t0y);
    end
    tests++;
    if ({len0, dead0, full0} !== {7'd3, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL init_len len=%0d dead=%0d full=%0d want 3 0 0", len0, dead0, full0);
    end
  endtask

  task automatic test_step_right();
    reset_dut();
    dir = 2'd3; grow = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    tests++;
    if ({busy0, h0x} !== {1'b1, 6'd20}) begin
      fails++;
      $display("FAIL move_cycle busy=%0d head_x=%0d want 1 20", busy0, h0x);
    end
    tick();
    tests++;
    if ({h0x, h0y, t0x, t0y} !== {6'd21, 6'd15, 6'd19, 6'd15}) begin
      fails++;
      $display("FAIL step_pos head (%0d,%0d) tail (%0d,%0d) want (21,15) (19,15)",
               h0x, h0y, t0x, t0y);
    end
    tests++;
    if ({vv0, v0x, v0y, done0} !== {1'b1, 6'd18, 6'd15, 1'b0}) begin
      fails++;
      $display("FAIL step_vac vv=%0d vac (%0d,%0d) done=%0d want 1 (18,15) 0",
               vv0, v0x, v0y, done0);
    end
    tick();
    tests++;
    if ({vv0, done0, busy0} !== {1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL step_scan vv=%0d done=%0d busy=%0d want 0 0 1", vv0, done0, busy0);
    end
    tick();
    tests++;
    if ({done0, busy0} !== {1'b1, 1'b0}) begin
      fails++;
      $display("FAIL step_done done=%0d busy=%0d want 1 0", done0, busy0);
    end
    tick();
    tests++;
    if (done0 !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse done=%0d want 0", done0);
    end
  endtask

  task automatic test_reversal();
    int c; bit sd0, sv0, sd1;
    reset_dut();
    step_wait(2'd2, 1'b0, c, sd0, sv0, sd1);
    tests++;
    if ({h0x, h0y, dead0, sd0} !== {6'd21, 6'd15, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reversal_left head (%0d,%0d) dead=%0d done=%0d want (21,15) 0 1",
               h0x, h0y, dead0, sd0);
    end
    tests++;
    if (c !== 4) begin
      fails++;
      $display("FAIL step_latency got %0d want 4", c);
    end
    step_wait(2'd0, 1'b0, c, sd0, sv0, sd1);
    step_wait(2'd1, 1'b0, c, sd0, sv0, sd1);
    tests++;
    if ({h0x, h0y} !== {6'd21, 6'd13}) begin
      fails++;
      $display("FAIL reversal_down head (%0d,%0d) want (21,13)", h0x, h0y);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    reset_dut();
    dir = 2'd3; grow = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    dir = 2'd0; step = 1'b1;
    tick();
    step = 1'b0;
    n = 0;
    while (busy0 && n < 20) begin
      tick();
      n++;
    end
    tick(); tick();
    tests++;
    if ({h0x, h0y, busy0} !== {6'd21, 6'd15, 1'b0}) begin
      fails++;
      $display("FAIL busy_step_ignored head (%0d,%0d) busy=%0d want (21,15) 0",
               h0x, h0y, busy0);
    end
  endtask

  task automatic test_growth();
    int c; bit sd0, sv0, sd1; int bad;
    logic [1:0] seg_dir [5];
    int seg_len [5];
    seg_dir = '{2'd3, 2'd1, 2'd2, 2'd1, 2'd3};
    seg_len = '{17, 1, 30, 1, 11};
    reset_dut();
    step_wait(2'd3, 1'b1, c, sd0, sv0, sd1);
    tests++;
    if ({len0, sv0, t0x, t0y, h0x} !== {7'd4, 1'b0, 6'd18, 6'd15, 6'd21}) begin
      fails++;
      $display("FAIL grow_one len=%0d vac_seen=%0d tail (%0d,%0d) head_x=%0d want 4 0 (18,15) 21",
               len0, sv0, t0x, t0y, h0x);
    end
    bad = 0;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < seg_len[s]; k++) begin
        step_wait(seg_dir[s], 1'b1, c, sd0, sv0, sd1);
        if (dead0 || !sd0 || sv0) bad++;
      end
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL grow_path bad_steps=%0d want 0", bad);
    end
    tests++;
    if ({len0, full0, dead0} !== {7'd64, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL grow_full len=%0d full=%0d dead=%0d want 64 1 0", len0, full0, dead0);
    end
    tests++;
    if ({h0x, h0y, t0x, t0y} !== {6'd19, 6'd17, 6'd18, 6'd15}) begin
      fails++;
      $display("FAIL grow_pos head (%0d,%0d) tail (%0d,%0d) want (19,17) (18,15)",
               h0x, h0y, t0x, t0y);
    end
    tests++;
    if (c !== 65) begin
      fails++;
      $display("FAIL full_latency got %0d want 65", c);
    end
    step_wait(2'd3, 1'b1, c, sd0, sv0, sd1);
    tests++;
    if ({len0, full0, sv0, sd0} !== {7'd64, 1'b1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL grow_sat len=%0d full=%0d vac_seen=%0d done=%0d want 64 1 1 1",
               len0, full0, sv0, sd0);
    end
    tests++;
    if ({h0x, h0y, t0x, t0y, v0x, v0y} !== {6'd20, 6'd17, 6'd19, 6'd15, 6'd18, 6'd15}) begin
      fails++;
      $display("FAIL sat_pos head (%0d,%0d) tail (%0d,%0d) vac (%0d,%0d) want (20,17) (19,15) (18,15)",
               h0x, h0y, t0x, t0y, v0x, v0y);
    end
  endtask

  task automatic test_wall();
    int c; bit sd0, sv0, sd1;
    reset_dut();
    for (int k = 0; k < 15; k++) step_wait(2'd0, 1'b0, c, sd0, sv0, sd1);
    tests++;
    if ({h0x, h0y, dead0, h1y} !== {6'd20, 6'd0, 1'b0, 6'd0}) begin
      fails++;
      $display("FAIL wall_approach head (%0d,%0d) dead=%0d wrap_y=%0d want (20,0) 0 0",
               h0x, h0y, dead0, h1y);
    end
    step_wait(2'd0, 1'b0, c, sd0, sv0, sd1);
    tick(); tick(); tick();
    tests++;
    if ({dead0, busy0, sd0, done0} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL wall_dead dead=%0d busy=%0d done_seen=%0d want 1 1 0", dead0, busy0, sd0);
    end
    tests++;
    if ({h0x, h0y, t0y, len0} !== {6'd20, 6'd0, 6'd2, 7'd3}) begin
      fails++;
      $display("FAIL wall_freeze head (%0d,%0d) tail_y=%0d len=%0d want (20,0) 2 3",
               h0x, h0y, t0y, len0);
    end
    tests++;
    if ({h1x, h1y, sd1, dead1} !== {6'd20, 6'd29, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL wrap_y head (%0d,%0d) done=%0d dead=%0d want (20,29) 1 0",
               h1x, h1y, sd1, dead1);
    end
  endtask

  task automatic build_coil();
    int c; bit sd0, sv0, sd1;
    reset_dut();
    step_wait(2'd3, 1'b1, c, sd0, sv0, sd1);
    step_wait(2'd3, 1'b1, c, sd0, sv0, sd1);
    step_wait(2'd1, 1'b0, c, sd0, sv0, sd1);
    step_wait(2'd2, 1'b0, c, sd0, sv0, sd1);
  endtask

  task automatic test_self_collision();
    int c; bit sd0, sv0, sd1; int n;
    build_coil();
    tests++;
    if ({len0, h0x, h0y, dead0} !== {7'd5, 6'd21, 6'd16, 1'b0}) begin
      fails++;
      $display("FAIL coil_setup len=%0d head (%0d,%0d) dead=%0d want 5 (21,16) 0",
               len0, h0x, h0y, dead0);
    end
    step_wait(2'd0, 1'b0, c, sd0, sv0, sd1);
    tests++;
    if ({dead0, dead1, sd0, sd1, c} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'd3}) begin
      fails++;
      $display("FAIL self_hit dead=%0d/%0d done=%0d/%0d cycles=%0d want 1/1 0/0 3",
               dead0, dead1, sd0, sd1, c);
    end
    tests++;
    if ({h0x, h0y, len0} !== {6'd21, 6'd15, 7'd5}) begin
      fails++;
      $display("FAIL self_hit_pos head (%0d,%0d) len=%0d want (21,15) 5", h0x, h0y, len0);
    end
    build_coil();
    dir = 2'd0; grow = 1'b0; step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tests++;
    if ({dead0, busy0, h0x, h0y} !== {1'b0, 1'b1, 6'd21, 6'd15}) begin
      fails++;
      $display("FAIL in_scan dead=%0d busy=%0d head (%0d,%0d) want 0 1 (21,15)",
               dead0, busy0, h0x, h0y);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({dead0, busy0, len0, vv0} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
      fails++;
      $display("FAIL scan_reset dead=%0d busy=%0d len=%0d vv=%0d want 0 1 0 0",
               dead0, busy0, len0, vv0);
    end
    n = 0;
    while (busy0 && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if ({n[3:0], h0x, h0y, len0, dead0} !== {4'd3, 6'd20, 6'd15, 7'd3, 1'b0}) begin
      fails++;
      $display("FAIL reinit cycles=%0d head (%0d,%0d) len=%0d dead=%0d want 3 (20,15) 3 0",
               n, h0x, h0y, len0, dead0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step_right();
    test_reversal();
    test_back_to_back();
    test_growth();
    test_wall();
    test_self_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
